// File: rtl/vid_pos_track.sv
// Video position tracker: registers DE/syncs, produces x/y position and frame pulse,
// measures active width/height and locks onto a stable geometry.
// Optional sync polarity detection is enabled by defining VID_POS_POL_DET_EN.
module vid_pos_track #(
  parameter int unsigned XW = 12,
  parameter int unsigned YW = 11
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          de_i,
  input  logic          hs_i,
  input  logic          vs_i,
  output logic          de_o,
  output logic          hs_o,
  output logic          vs_o,
  output logic [XW-1:0] x_o,
  output logic [YW-1:0] y_o,
  output logic          frame_o,
  output logic [XW-1:0] width_o,
  output logic [YW-1:0] height_o,
  output logic          locked_o
);

  typedef enum logic [1:0] {StUnlock, StMeas, StLock} state_e;

  localparam logic [XW-1:0] XMax = '1;
  localparam logic [YW-1:0] YMax = '1;

  state_e        r_state;
  logic [YW-1:0] r_ycnt;
  logic [XW-1:0] r_ref_len;
  logic          r_first_done;
  logic          r_err;
  logic          r_run;

  state_e        w_state_d;
  logic          w_hs_n, w_vs_n;
  logic          w_de_fall, w_vs_rise, w_fall_cnt;
  logic [XW-1:0] w_len, w_first_len, w_x_d;
  logic [YW-1:0] w_lines, w_ycnt_d;
  logic          w_len_err, w_err;

`ifdef VID_POS_POL_DET_EN
  logic r_hs_pol, r_vs_pol;

  // Sync levels seen at the start of active video are taken as the idle level.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_hs_pol <= 1'b0;
      r_vs_pol <= 1'b0;
    end else if (de_i && !de_o) begin
      r_hs_pol <= hs_i;
      r_vs_pol <= vs_i;
    end
  end

  assign w_hs_n = hs_i ^ r_hs_pol;
  assign w_vs_n = vs_i ^ r_vs_pol;
`else
  assign w_hs_n = hs_i;
  assign w_vs_n = vs_i;
`endif

  assign w_de_fall  = !de_i && de_o;
  assign w_vs_rise  = w_vs_n && !vs_o;
  // Lines are only counted once the first frame boundary after reset has been seen.
  assign w_fall_cnt = w_de_fall && r_run;
  assign w_len      = (x_o == XMax) ? XMax : x_o + XW'(1);
  assign w_lines    = (w_fall_cnt && r_ycnt != YMax) ? r_ycnt + YW'(1) : r_ycnt;
  assign w_first_len = r_first_done ? r_ref_len : w_len;
  assign w_len_err  = w_fall_cnt && r_first_done && (w_len != r_ref_len);
  assign w_err      = r_err || w_len_err;

  always_comb begin
    w_x_d = '0;
    if (de_i && de_o) begin
      w_x_d = (x_o == XMax) ? XMax : x_o + XW'(1);
    end
  end

  always_comb begin
    w_ycnt_d = r_ycnt;
    if (w_vs_rise) begin
      w_ycnt_d = '0;
    end else if (w_fall_cnt && r_ycnt != YMax) begin
      w_ycnt_d = r_ycnt + YW'(1);
    end
  end

  always_comb begin
    w_state_d = r_state;
    if (w_vs_rise) begin
      case (r_state)
        StUnlock: w_state_d = StMeas;
        StMeas:   w_state_d = (!w_err && w_lines != '0) ? StLock : StMeas;
        StLock: begin
          if (w_err || w_lines != height_o || w_first_len != width_o) begin
            w_state_d = StUnlock;
          end
        end
        default:  w_state_d = StUnlock;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      de_o         <= 1'b0;
      hs_o         <= 1'b0;
      vs_o         <= 1'b0;
      x_o          <= '0;
      y_o          <= '0;
      frame_o      <= 1'b0;
      width_o      <= '0;
      height_o     <= '0;
      locked_o     <= 1'b0;
      r_state      <= StUnlock;
      r_ycnt       <= '0;
      r_ref_len    <= '0;
      r_first_done <= 1'b0;
      r_err        <= 1'b0;
      r_run        <= 1'b0;
    end else begin
      de_o     <= de_i;
      hs_o     <= w_hs_n;
      vs_o     <= w_vs_n;
      frame_o  <= w_vs_rise;
      x_o      <= w_x_d;
      y_o      <= de_i ? w_ycnt_d : '0;
      r_ycnt   <= w_ycnt_d;
      r_state  <= w_state_d;
      locked_o <= (w_state_d == StLock);

      if (w_fall_cnt && !r_first_done && r_state != StLock) begin
        width_o <= w_len;
      end

      // A line ending on the vs edge belongs to the frame being closed.
      if (w_vs_rise) begin
        r_run        <= 1'b1;
        height_o     <= w_lines;
        r_err        <= 1'b0;
        r_first_done <= 1'b0;
        r_ref_len    <= '0;
      end else if (w_fall_cnt) begin
        if (!r_first_done) begin
          r_ref_len    <= w_len;
          r_first_done <= 1'b1;
        end
        r_err <= w_err;
      end
    end
  end

endmodule
